// File: rtl/toggle_pkg.sv
// Shared constants for the 2-phase toggle protocol. The sender-side checkers
// reuse these as well as the receiver.
package toggle_pkg;

   localparam int DEF_SYNC_STAGES = 2;

   // Width needed to hold a count from 0 up to max_pend inclusive
   function automatic int pend_cnt_w(input int max_pend);
      return $clog2(max_pend + 1);
   endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser that brings the asynchronous toggle level into the
// clk domain.
module toggle_sync
   import toggle_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s_lvl
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s_lvl = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Receiving end of the 2-phase toggle protocol: every transition of tgl_in
// becomes one queued event, and every accepted event flips ack_tgl once.
module toggle_event_receiver
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int MAX_PEND    = 4,
   parameter int TOT_W       = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            tgl_in,
   output logic                            evt_valid,
   input  logic                            evt_ready,
   output logic                            ack_tgl,
   output logic [pend_cnt_w(MAX_PEND)-1:0] pend_cnt,
   output logic [TOT_W-1:0]                tot_cnt,
   output logic                            ovf,
   input  logic                            ovf_clr
);

   localparam int PEND_W   = pend_cnt_w(MAX_PEND);
   localparam int SETTLE_N = SYNC_STAGES + 1;
   localparam int SETTLE_W = $clog2(SETTLE_N + 1);

   localparam logic [PEND_W-1:0]   PEND_MAX    = PEND_W'(MAX_PEND);
   localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE_N);

   logic                s_lvl;
   logic                prev_lvl_q;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic [TOT_W-1:0]    tot_q, tot_d;
   logic                ack_q, ack_d;
   logic                ovf_q, ovf_d;
   logic                armed;
   logic                lvl_edge;
   logic                pop;

   toggle_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tgl_in),
      .s_lvl (s_lvl)
   );

   // Edges are ignored until the synchroniser chain and prev_lvl have been
   // refilled from tgl_in, so a level held through reset is not an event.
   assign armed     = (settle_q == SETTLE_DONE);
   assign lvl_edge  = armed & (s_lvl ^ prev_lvl_q);
   assign evt_valid = (pend_q != '0);
   assign pop       = evt_valid & evt_ready;

   always_comb begin
      settle_d = settle_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      ack_d    = ack_q ^ pop;
      tot_d    = pop ? (tot_q + TOT_W'(1)) : tot_q;

      if (!armed) begin
         settle_d = settle_q + SETTLE_W'(1);
      end

      if (ovf_clr) begin
         ovf_d = 1'b0;
      end

      // A simultaneous edge and pop frees and refills one slot, so it never overflows
      if (lvl_edge && !pop) begin
         if (pend_q < PEND_MAX) begin
            pend_d = pend_q + PEND_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end else if (pop && !lvl_edge) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_lvl_q <= 1'b0;
         settle_q   <= '0;
         pend_q     <= '0;
         tot_q      <= '0;
         ack_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         prev_lvl_q <= s_lvl;
         settle_q   <= settle_d;
         pend_q     <= pend_d;
         tot_q      <= tot_d;
         ack_q      <= ack_d;
         ovf_q      <= ovf_d;
      end
   end

   assign pend_cnt = pend_q;
   assign tot_cnt  = tot_q;
   assign ack_tgl  = ack_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver (SYNC_STAGES=2, MAX_PEND=4, TOT_W=4).
module tb_toggle_event_receiver;

   logic       clk;
   logic       rst_n;
   logic       tgl_in;
   logic       evt_valid;
   logic       evt_ready;
   logic       ack_tgl;
   logic [2:0] pend_cnt;
   logic [3:0] tot_cnt;
   logic       ovf;
   logic       ovf_clr;

   int checks = 0;
   int errors = 0;
   int tot_exp = 0;
   int ack_exp = 0;

   toggle_event_receiver #(
      .SYNC_STAGES (2),
      .MAX_PEND    (4),
      .TOT_W       (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgl_in    (tgl_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .ack_tgl   (ack_tgl),
      .pend_cnt  (pend_cnt),
      .tot_cnt   (tot_cnt),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance n clock edges and settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One transition, then enough edges for it to reach pend_cnt (3) plus spacing
   task automatic toggle_and_wait(input int n);
      tgl_in = ~tgl_in;
      tick(n);
   endtask

   // Consumer accepts one event per cycle; model the acknowledge and count
   task automatic pop_n(input int n, input string tag);
      evt_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick(1);
         ack_exp = ack_exp ^ 1;
         tot_exp = (tot_exp + 1) % 16;
         check_val({tag, "_ack"}, ack_tgl, ack_exp);
      end
      evt_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      tgl_in    = 1'b1;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      tick(2);
      check_val("rst_valid", evt_valid, 0);
      check_val("rst_pend", pend_cnt, 0);
      check_val("rst_ack", ack_tgl, 0);
      check_val("rst_tot", tot_cnt, 0);
      check_val("rst_ovf", ovf, 0);

      // Level held at 1 through release must not create an event
      rst_n = 1'b1;
      tick(10);
      check_val("arm_valid", evt_valid, 0);
      check_val("arm_pend", pend_cnt, 0);
      check_val("arm_ovf", ovf, 0);

      // Single transition: visible after the 3rd sampling edge
      tgl_in = ~tgl_in;
      tick(2);
      check_val("lat_valid_early", evt_valid, 0);
      tick(1);
      check_val("lat_valid", evt_valid, 1);
      check_val("lat_pend", pend_cnt, 1);
      pop_n(1, "single");
      check_val("single_pend", pend_cnt, 0);
      check_val("single_tot", tot_cnt, tot_exp);
      check_val("single_valid", evt_valid, 0);
      tick(3);
      check_val("single_once", pend_cnt, 0);

      // evt_ready with nothing pending does nothing
      evt_ready = 1'b1;
      tick(2);
      evt_ready = 1'b0;
      check_val("idle_ready_ack", ack_tgl, ack_exp);
      check_val("idle_ready_tot", tot_cnt, tot_exp);

      // Six transitions into a 4-deep queue: saturate and flag overflow
      for (int i = 0; i < 6; i++) begin
         toggle_and_wait(4);
         if (i == 3) begin
            check_val("sat_pend4_ovf", ovf, 0);
         end
      end
      check_val("sat_pend", pend_cnt, 4);
      check_val("sat_ovf", ovf, 1);
      pop_n(4, "drain4");
      check_val("drain4_tot", tot_cnt, tot_exp);
      check_val("drain4_valid", evt_valid, 0);
      check_val("drain4_ovf_sticky", ovf, 1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check_val("ovf_clr", ovf, 0);

      // Refill to 4, then a synchronised edge coincident with a pop
      for (int i = 0; i < 4; i++) begin
         toggle_and_wait(4);
      end
      check_val("full_pend", pend_cnt, 4);
      tgl_in = ~tgl_in;
      tick(2);
      pop_n(1, "edge_pop");
      check_val("edge_pop_pend", pend_cnt, 4);
      check_val("edge_pop_ovf", ovf, 0);
      check_val("edge_pop_tot", tot_cnt, tot_exp);

      // Dropped edge with ovf_clr in the same cycle: set wins
      tgl_in = ~tgl_in;
      tick(2);
      ovf_clr = 1'b1;
      tick(1);
      check_val("set_clr_ovf", ovf, 1);
      check_val("set_clr_pend", pend_cnt, 4);
      tick(1);
      ovf_clr = 1'b0;
      check_val("clr_only_ovf", ovf, 0);

      // Drain, then keep accepting until tot_cnt has passed 16 events and wrapped
      pop_n(4, "drain_b");
      check_val("drain_b_pend", pend_cnt, 0);
      while (tot_exp != 1) begin
         toggle_and_wait(3);
         pop_n(1, "wrap");
      end
      check_val("wrap_tot", tot_cnt, 1);
      check_val("wrap_ack", ack_tgl, ack_exp);

      // Mid-operation reset with two events pending clears without a clock
      toggle_and_wait(4);
      toggle_and_wait(4);
      check_val("pre_rst_pend", pend_cnt, 2);
      rst_n = 1'b0;
      #2;
      check_val("async_rst_valid", evt_valid, 0);
      check_val("async_rst_pend", pend_cnt, 0);
      check_val("async_rst_ack", ack_tgl, 0);
      check_val("async_rst_tot", tot_cnt, 0);
      check_val("async_rst_ovf", ovf, 0);

      // Arming restarts: a level of 1 held across release is not an event
      tgl_in = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      check_val("rearm_pend", pend_cnt, 0);
      check_val("rearm_valid", evt_valid, 0);
      tgl_in = 1'b0;
      tick(3);
      check_val("rearm_event", pend_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
- Receiving end of the 2-phase toggle protocol driven by toggle_module.
- Synchronises an incoming toggling level and turns every transition (rise or fall) into one queued event.
- Presents queued events on a valid/ready interface.
- Returns a 2-phase acknowledge toggle for each event the consumer accepts, so the sender's side can close the handshake.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on tgl_in; legal values are 2 and above.
- MAX_PEND, 4, maximum number of events held pending; legal values are 1 and above.
- TOT_W, 16, width of the free-running accepted-event counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- tgl_in  input  1  incoming toggle level, asynchronous to clk.
- evt_valid  output  1  at least one event is pending.
- evt_ready  input  1  consumer accepts an event when high together with evt_valid.
- ack_tgl  output  1  2-phase acknowledge; flips once per accepted event.
- pend_cnt  output  $clog2(MAX_PEND+1)  number of events currently pending.
- tot_cnt  output  TOT_W  accepted-event count, modulo 2^TOT_W.
- ovf  output  1  sticky; an edge arrived while pend_cnt == MAX_PEND.
- ovf_clr  input  1  synchronous clear for ovf.

Behaviour:
- Reset (asynchronous assert, synchronous release): all synchroniser flops, the previous-level flop, pend_cnt, tot_cnt, ack_tgl and ovf are 0. evt_valid is therefore 0.
- Synchroniser:
  - tgl_in passes through SYNC_STAGES flops to give s_lvl.
  - prev_lvl <= s_lvl every cycle.
  - edge = s_lvl ^ prev_lvl.
- Arming:
  - A settle counter suppresses edge for the first SYNC_STAGES+1 rising clk edges after rst_n deasserts.
  - prev_lvl still tracks s_lvl during settling.
  - A tgl_in held at 1 through reset release produces no event.
- Latency: define the first clk edge that samples a new tgl_in level as edge 0. The edge is seen between edges SYNC_STAGES-1 and SYNC_STAGES. pend_cnt increments and evt_valid rises after edge SYNC_STAGES. With the default, evt_valid is high after the 3rd sampling edge.
- pop = evt_valid & evt_ready. evt_valid = (pend_cnt != 0), driven combinationally from the registered counter.
- Pending counter update:
  - edge and not pop: pend_cnt+1 if pend_cnt < MAX_PEND; otherwise pend_cnt is unchanged, the event is dropped, and ovf is set.
  - pop and not edge: pend_cnt-1.
  - edge and pop together: pend_cnt is unchanged, even when pend_cnt == MAX_PEND. No overflow, since a slot is freed in the same cycle.
- evt_ready while evt_valid is low has no effect.
- On pop:
  - ack_tgl <= ~ack_tgl (registered; visible the cycle after pop).
  - tot_cnt <= tot_cnt+1, wrapping from 2^TOT_W-1 to 0.
- A single tgl_in transition yields exactly one event. Two transitions that are resolved on separate s_lvl cycles yield two events. A pulse shorter than one clk period may be lost; this is protocol-legal because the sender's toggles are level-held.
- ovf:
  - Set on a dropped edge.
  - Cleared by ovf_clr.
  - If set and clear coincide, set wins.
- rst_n asserted mid-operation: pending events are discarded, counters clear, ack_tgl returns to 0, and arming restarts on release.

Decomposition:
- toggle_pkg holds the shared constants: the default SYNC_STAGES, and the pend_cnt width function clog2(MAX_PEND+1), reused by toggle_module-side checkers.
- Sub-module toggle_sync contains the SYNC_STAGES flop chain, an asynchronous active-low reset, and output s_lvl. It is instantiated once.
- The edge detection, arming, counters and handshake live in the top module.

Test Plan:
- Reset release with tgl_in=1, evt_ready=0 for 10 cycles -> evt_valid stays 0, pend_cnt=0, ovf=0.
- Armed, tgl_in 0->1, evt_ready=0 -> evt_valid rises after the 3rd sampling edge with pend_cnt=1. Then evt_ready=1 for one cycle -> pend_cnt=0, ack_tgl=1 the next cycle, tot_cnt=1.
- evt_ready=0 and 6 tgl_in transitions spaced 4 cycles apart -> pend_cnt saturates at 4 and ovf=1. Then evt_ready=1 for 4 cycles -> ack_tgl flips 4 times (ending at 0), tot_cnt=4, evt_valid=0.
- pend_cnt=4 and a synchronised edge in the same cycle as a pop -> pend_cnt stays 4, ovf stays 0.
- ovf=1 and ovf_clr=1 in the same cycle as a dropped edge -> ovf remains 1. ovf_clr alone on the next cycle -> ovf=0.
- With TOT_W=4, accept 17 events -> tot_cnt wraps to 1. Assert rst_n=0 with pend_cnt=2 -> all outputs are 0 immediately, with no clock needed.
